// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and the SPI target.
package spi_pkg;

  localparam int SPI_BYTE_W       = 8;
  localparam int SPI_SYNC_DEFAULT = 2;

  // Mode number is {cpol, cpha}, identical encoding on both ends of the bus.
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  function automatic logic mode_cpol(input spi_mode_e m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-bit flop synchronizer with a per-bit reset value.
module spi_sync
  import spi_pkg::*;
#(
  parameter int                 WIDTH     = 1,
  parameter int                 STAGES    = SPI_SYNC_DEFAULT,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift the asynchronous pins through STAGES flops; reset forces the idle pin levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// 8-bit full-duplex SPI target, oversampling SCLK/CS_N/MOSI in the clk domain.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  csn,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [SPI_BYTE_W-1:0] din,
  input  logic                  din_vld,
  output logic                  din_rdy,
  output logic [SPI_BYTE_W-1:0] dout,
  output logic                  dout_vld,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam logic [1:0] FLUSH = 2'(SYNC_STAGES);

  logic [2:0]            pins_s;
  logic                  sclk_s, csn_s, mosi_s;
  logic                  sclk_d, csn_d;
  logic [1:0]            flush_cnt;
  logic                  armed;
  spi_mode_e             mode;
  logic                  sclk_edge, leading, trailing;
  logic                  sample_edge, shift_edge;
  logic                  cs_fall, cs_rise, cs_act;
  logic                  do_load, do_write;
  logic [SPI_BYTE_W-1:0] tx_sr, rx_sr, hold;
  logic                  hold_full;
  logic [2:0]            cnt;
  logic                  first;

  spi_sync #(
    .WIDTH     (3),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (3'b010)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({sclk, csn, mosi}),
    .q   (pins_s)
  );

  assign {sclk_s, csn_s, mosi_s} = pins_s;

  assign mode        = spi_mode_e'({cpol, cpha});
  assign sclk_edge   = sclk_s != sclk_d;
  assign leading     = sclk_edge && (sclk_s != mode_cpol(mode));
  assign trailing    = sclk_edge && (sclk_s == mode_cpol(mode));
  assign sample_edge = mode_cpha(mode) ? trailing : leading;
  assign shift_edge  = mode_cpha(mode) ? leading  : trailing;

  assign cs_fall  = armed && csn_d && !csn_s;
  assign cs_rise  = !csn_d && csn_s;
  assign cs_act   = armed && !csn_s;

  assign do_load  = cs_fall || (cs_act && shift_edge && (cnt == 3'd0) && !first);
  assign do_write = din_vld && !hold_full;

  assign din_rdy  = ~hold_full;
  assign miso_oe  = ~csn_s;
  assign busy     = ~csn_s;

  // Delayed pin copies for edge detection, plus arming once the synchronizer
  // has flushed and CS is seen idle, so a CS held low across reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d    <= 1'b0;
      csn_d     <= 1'b1;
      flush_cnt <= 2'd0;
      armed     <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      csn_d  <= csn_s;
      if (flush_cnt != FLUSH) begin
        flush_cnt <= flush_cnt + 2'd1;
      end else if (csn_s) begin
        armed <= 1'b1;
      end
    end
  end

  // One-entry transmit holding register; a load drains it, an empty load underruns.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      hold_full   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= do_load && !hold_full;
      if (do_write) begin
        hold      <= din;
        hold_full <= 1'b1;
      end else if (do_load) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Transmit shifter: loads at CS fall and at byte boundaries, shifts on shift edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr <= '0;
      miso  <= 1'b0;
    end else begin
      miso <= tx_sr[SPI_BYTE_W-1];
      if (do_load) begin
        tx_sr <= hold_full ? hold : '0;
      end else if (cs_act && !cs_fall && shift_edge && (cnt != 3'd0)) begin
        tx_sr <= tx_sr << 1;
      end
    end
  end

  // Receive shifter and bit counter; CS rise aborts any partial byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr    <= '0;
      cnt      <= 3'd0;
      first    <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      if (cs_fall) begin
        cnt   <= 3'd0;
        first <= 1'b1;
        rx_sr <= '0;
      end else if (cs_rise) begin
        cnt   <= 3'd0;
        rx_sr <= '0;
      end else if (cs_act && sample_edge) begin
        rx_sr <= {rx_sr[SPI_BYTE_W-2:0], mosi_s};
        cnt   <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          dout     <= {rx_sr[SPI_BYTE_W-2:0], mosi_s};
          dout_vld <= 1'b1;
          first    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave acting as the SPI bus master.
module tb_spi_slave;

  logic       clk;
  logic       rst;
  logic       sclk, csn, mosi;
  logic       miso, miso_oe;
  logic       cpol, cpha;
  logic [7:0] din;
  logic       din_vld, din_rdy;
  logic [7:0] dout;
  logic       dout_vld, tx_underrun, busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Monitor state (written only by the monitor process)
  int         vld_cnt = 0;
  int         ur_cnt  = 0;
  logic [7:0] rx_log [64];

  // Transmit feed for the holding register
  logic [7:0] feed [4];
  int         feed_n   = 0;
  int         feed_idx = 0;

  logic       ur_at2, ur_at3;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .csn         (csn),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .cpol        (cpol),
    .cpha        (cpha),
    .din         (din),
    .din_vld     (din_vld),
    .din_rdy     (din_rdy),
    .dout        (dout),
    .dout_vld    (dout_vld),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed bytes and underrun pulses away from the active edge.
  always @(negedge clk) begin
    if (dout_vld) begin
      rx_log[vld_cnt % 64] <= dout;
      vld_cnt <= vld_cnt + 1;
    end
    if (tx_underrun) ur_cnt <= ur_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, servicing the holding-register feed.
  task automatic cyc();
    logic acc;
    acc = din_vld && din_rdy;
    @(posedge clk);
    #1;
    if (acc) begin
      feed_idx++;
      din_vld = 1'b0;
    end
    if (!din_vld && (feed_idx < feed_n) && din_rdy) begin
      din     = feed[feed_idx];
      din_vld = 1'b1;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Act as the bus master: send nbits of mo (MSB first), collect miso into mi.
  task automatic applyStimulus(input logic p, input logic h, input int nbits,
                               input logic [23:0] mo, output logic [23:0] mi);
    mi   = '0;
    cpol = p;
    cpha = h;
    sclk = p;
    cycles(4);
    csn  = 1'b0;
    if (!h) mosi = mo[nbits-1];
    cyc(); cyc();
    ur_at2 = tx_underrun;
    cyc();
    ur_at3 = tx_underrun;
    cyc();
    for (int k = 0; k < nbits; k++) begin
      if (!h) begin
        mi   = {mi[22:0], miso};
        sclk = ~p;
        cycles(4);
        sclk = p;
        if (k + 1 < nbits) mosi = mo[nbits-2-k];
        cycles(4);
      end else begin
        sclk = ~p;
        mosi = mo[nbits-1-k];
        cycles(4);
        mi   = {mi[22:0], miso};
        sclk = p;
        cycles(4);
      end
    end
    csn = 1'b1;
    cycles(6);
  endtask

  task automatic setFeed(input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    feed[0]  = b0;
    feed[1]  = b1;
    feed[2]  = b2;
    feed[3]  = b3;
    feed_n   = n;
    feed_idx = 0;
  endtask

  initial begin
    logic [23:0] mi;
    int          vb, ub;

    rst = 1'b1; sclk = 1'b0; csn = 1'b1; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; din = 8'h00; din_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_miso",     {31'd0, miso},        32'd0);
    checkOutput("rst_miso_oe",  {31'd0, miso_oe},     32'd0);
    checkOutput("rst_din_rdy",  {31'd0, din_rdy},     32'd1);
    checkOutput("rst_dout",     {24'd0, dout},        32'd0);
    checkOutput("rst_dout_vld", {31'd0, dout_vld},    32'd0);
    checkOutput("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    checkOutput("rst_busy",     {31'd0, busy},        32'd0);
    rst = 1'b0;
    cycles(6);

    // Mode 0 single byte, filler byte covers the final trailing-edge load
    vb = vld_cnt; ub = ur_cnt;
    setFeed(2, 8'h3C, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 8, 24'h0000A5, mi);
    checkOutput("m0_dout",     {24'd0, dout},  32'hA5);
    checkOutput("m0_vld_cnt",  vld_cnt - vb,   32'd1);
    checkOutput("m0_miso",     {8'd0, mi},     32'h3C);
    checkOutput("m0_underrun", ur_cnt - ub,    32'd0);
    checkOutput("m0_busy_end", {31'd0, busy},  32'd0);

    // Modes 1, 2, 3
    vb = vld_cnt; ub = ur_cnt;
    setFeed(1, 8'h7E, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b1, 8, 24'h000081, mi);
    checkOutput("m1_dout", {24'd0, dout}, 32'h81);
    checkOutput("m1_miso", {8'd0, mi},    32'h7E);
    checkOutput("m1_vld",  vld_cnt - vb,  32'd1);

    vb = vld_cnt;
    setFeed(2, 8'h7E, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 8, 24'h000081, mi);
    checkOutput("m2_dout", {24'd0, dout}, 32'h81);
    checkOutput("m2_miso", {8'd0, mi},    32'h7E);
    checkOutput("m2_vld",  vld_cnt - vb,  32'd1);

    vb = vld_cnt;
    setFeed(1, 8'h7E, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b1, 8, 24'h000081, mi);
    checkOutput("m3_dout", {24'd0, dout}, 32'h81);
    checkOutput("m3_miso", {8'd0, mi},    32'h7E);
    checkOutput("m3_vld",  vld_cnt - vb,  32'd1);
    checkOutput("m123_underrun", ur_cnt - ub, 32'd0);

    // Three back-to-back bytes in one CS, mode 0
    vb = vld_cnt; ub = ur_cnt;
    setFeed(4, 8'hDE, 8'hAD, 8'hBE, 8'h00);
    applyStimulus(1'b0, 1'b0, 24, 24'h112233, mi);
    checkOutput("b2b_vld_cnt",  vld_cnt - vb,        32'd3);
    checkOutput("b2b_byte0",    {24'd0, rx_log[vb]},   32'h11);
    checkOutput("b2b_byte1",    {24'd0, rx_log[vb+1]}, 32'h22);
    checkOutput("b2b_byte2",    {24'd0, rx_log[vb+2]}, 32'h33);
    checkOutput("b2b_miso",     {8'd0, mi},          32'hDEADBE);
    checkOutput("b2b_underrun", ur_cnt - ub,         32'd0);

    // Empty holding register at CS fall, mode 0
    vb = vld_cnt; ub = ur_cnt;
    setFeed(0, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 8, 24'h00005A, mi);
    checkOutput("ur_cycle2",  {31'd0, ur_at2}, 32'd0);
    checkOutput("ur_cycle3",  {31'd0, ur_at3}, 32'd1);
    checkOutput("ur_miso",    {8'd0, mi},      32'h00);
    checkOutput("ur_dout",    {24'd0, dout},   32'h5A);
    checkOutput("ur_count",   ur_cnt - ub,     32'd2);
    checkOutput("ur_vld_cnt", vld_cnt - vb,    32'd1);

    // CS rises after 5 bits, then a clean transfer
    vb = vld_cnt;
    setFeed(1, 8'h55, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 5, 24'h00001F, mi);
    checkOutput("abort_no_vld", vld_cnt - vb,  32'd0);
    checkOutput("abort_dout",   {24'd0, dout}, 32'h5A);
    vb = vld_cnt; ub = ur_cnt;
    setFeed(2, 8'h96, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 8, 24'h0000C3, mi);
    checkOutput("post_abort_dout", {24'd0, dout}, 32'hC3);
    checkOutput("post_abort_vld",  vld_cnt - vb,  32'd1);
    checkOutput("post_abort_miso", {8'd0, mi},    32'h96);
    checkOutput("post_abort_ur",   ur_cnt - ub,   32'd0);

    // Reset asserted mid-byte
    setFeed(1, 8'h33, 8'h00, 8'h00, 8'h00);
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; mosi = 1'b1;
    cycles(4);
    csn = 1'b0;
    cycles(6);
    sclk = 1'b1; cycles(4);
    sclk = 1'b0; cycles(4);
    sclk = 1'b1; cycles(2);
    rst = 1'b1;
    cyc();
    checkOutput("mid_rst_miso",     {31'd0, miso},        32'd0);
    checkOutput("mid_rst_miso_oe",  {31'd0, miso_oe},     32'd0);
    checkOutput("mid_rst_din_rdy",  {31'd0, din_rdy},     32'd1);
    checkOutput("mid_rst_dout",     {24'd0, dout},        32'd0);
    checkOutput("mid_rst_dout_vld", {31'd0, dout_vld},    32'd0);
    checkOutput("mid_rst_underrun", {31'd0, tx_underrun}, 32'd0);
    checkOutput("mid_rst_busy",     {31'd0, busy},        32'd0);
    rst = 1'b0;
    sclk = 1'b0; cycles(4);
    sclk = 1'b1; cycles(4);
    sclk = 1'b0; cycles(4);
    csn = 1'b1;
    cycles(8);
    vb = vld_cnt; ub = ur_cnt;
    setFeed(2, 8'hA7, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 8, 24'h00005A, mi);
    checkOutput("post_rst_dout", {24'd0, dout}, 32'h5A);
    checkOutput("post_rst_vld",  vld_cnt - vb,  32'd1);
    checkOutput("post_rst_miso", {8'd0, mi},    32'hA7);
    checkOutput("post_rst_ur",   ur_cnt - ub,   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
